// File: rtl/det_1011_sched.sv
// One overlapping "1011" detector shared by NCH bit-stream channels through a round-robin arbiter.
// Optional per-channel saturating match counters are built when DET_1011_SCHED_CNT_EN is defined.
module det_1011_sched #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] x,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] gnt,
  output logic           det_vld,
  output logic [CW-1:0]  det_ch,
  input  logic [CW-1:0]  rd_sel,
  output logic [7:0]     cnt_out
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  function automatic state_e next_state(input state_e s, input logic b);
    state_e n;
    case (s)
      S0:      n = b ? S1    : S0;
      S1:      n = b ? S1    : S10;
      S10:     n = b ? S101  : S0;
      S101:    n = b ? S1011 : S10;
      S1011:   n = b ? S1    : S10;
      default: n = S0;
    endcase
    return n;
  endfunction

  state_e          ctx_q [NCH];
  state_e          ctx_d [NCH];
  logic [CW-1:0]   ptr_q, ptr_d;
  logic            det_vld_q, det_vld_d;
  logic [CW-1:0]   det_ch_q, det_ch_d;

  logic [NCH-1:0]  elig;
  logic            gnt_any;
  logic [CW-1:0]   gnt_idx;
  state_e          gnt_next;

  assign elig = req & ~clr;

  // Search begins just past the last granted channel so every requester waits at most NCH cycles.
  always_comb begin : p_arb
    logic [CW-1:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(ptr_q) + k) % NCH);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign gnt_next = next_state(ctx_q[gnt_idx], x[gnt_idx]);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ctx_d[i] = ctx_q[i];
      if (clr[i])      ctx_d[i] = S0;
      else if (gnt[i]) ctx_d[i] = gnt_next;
    end
    ptr_d     = gnt_any ? gnt_idx : ptr_q;
    det_vld_d = gnt_any && (gnt_next == S1011);
    det_ch_d  = det_vld_d ? gnt_idx : det_ch_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S0;
      ptr_q     <= CW'(NCH - 1);
      det_vld_q <= 1'b0;
      det_ch_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= ctx_d[i];
      ptr_q     <= ptr_d;
      det_vld_q <= det_vld_d;
      det_ch_q  <= det_ch_d;
    end
  end

  assign det_vld = det_vld_q;
  assign det_ch  = det_ch_q;

`ifdef DET_1011_SCHED_CNT_EN
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_d [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i])
        cnt_d[i] = 8'd0;
      else if (det_vld_d && (gnt_idx == CW'(i)) && (cnt_q[i] != 8'hFF))
        cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Selects beyond NCH-1 are possible when NCH is not a power of two.
  assign cnt_out = (int'(rd_sel) < NCH) ? cnt_q[rd_sel] : 8'd0;
`else
  logic unused_rd_sel;
  assign unused_rd_sel = ^rd_sel;
  assign cnt_out       = 8'd0;
`endif

endmodule

// File: tb/tb_det_1011_sched.sv
// Directed self-checking bench for det_1011_sched (NCH=4); expected counter values follow
// DET_1011_SCHED_CNT_EN so the bench is valid with the macro defined or undefined.
module tb_det_1011_sched;

`ifdef DET_1011_SCHED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, x, clr, gnt;
  logic       det_vld;
  logic [1:0] det_ch, rd_sel;
  logic [7:0] cnt_out;

  int tests = 0;
  int fails = 0;

  det_1011_sched #(.NCH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .x       (x),
    .clr     (clr),
    .gnt     (gnt),
    .det_vld (det_vld),
    .det_ch  (det_ch),
    .rd_sel  (rd_sel),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check the combinational grant, clock it, then check the detection outputs.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] xv,
                      input logic [3:0] c, input logic [3:0] eg, input logic ed,
                      input logic [1:0] ec);
    req = r; x = xv; clr = c;
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk); #1;
    check({tag, ".det_vld"}, 32'(det_vld), 32'(ed));
    check({tag, ".det_ch"}, 32'(det_ch), 32'(ec));
    $display("[TB] %s req=%b x=%b clr=%b gnt=%b det_vld=%0b det_ch=%0d",
             tag, r, xv, c, eg, det_vld, det_ch);
    req = '0; x = '0; clr = '0;
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input int exp);
    rd_sel = sel;
    #1;
    check({tag, ".cnt"}, 32'(cnt_out), CNT_EN ? exp : 0);
  endtask

  task automatic reset_dut(input string tag);
    rst_n = 1'b0; req = '0; x = '0; clr = '0; rd_sel = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check({tag, ".rst_det_vld"}, 32'(det_vld), 0);
    check({tag, ".rst_det_ch"}, 32'(det_ch), 0);
    check({tag, ".rst_gnt_idle"}, 32'(gnt), 0);
    for (int i = 0; i < 4; i++) chk_cnt({tag, ".rst"}, 2'(i), 0);
  endtask

  logic [6:0] bits7;
  logic [3:0] pat;

  initial begin
    rst_n = 1'b0; req = '0; x = '0; clr = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_dut("t1");

    // Single channel 0: 1,0,1,1,0,1,1 -> detections after the 4th and 7th bits.
    bits7 = 7'b1011011;
    for (int i = 0; i < 7; i++)
      step($sformatf("t1.b%0d", i), 4'b0001, {3'b000, bits7[6-i]}, 4'b0000, 4'b0001,
           (i == 3) || (i == 6), 2'd0);
    chk_cnt("t1.ch0", 2'd0, 2);

    // All four requesting: round robin from channel 0, each channel receives 1,0,1,1.
    reset_dut("t2");
    pat = 4'b1011;
    for (int rnd = 0; rnd < 4; rnd++)
      for (int ch = 0; ch < 4; ch++)
        step($sformatf("t2.r%0d.c%0d", rnd, ch), 4'b1111, pat[3-rnd] ? 4'b1111 : 4'b0000,
             4'b0000, 4'(1 << ch), rnd == 3, (rnd == 3) ? 2'(ch) : 2'd0);
    chk_cnt("t2.ch3", 2'd3, 1);
    chk_cnt("t2.ch1", 2'd1, 1);

    // Interleaved ch1 (1,0,1,1) and ch2 (1,1,1): only ch1 detects.
    step("t3.a", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd3);
    step("t3.b", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd3);
    step("t3.c", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd3);
    step("t3.d", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd3);
    step("t3.e", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd3);
    step("t3.f", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd3);
    step("t3.g", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1);
    // ch2 must be in S1: 0,1,1 completes a match.
    step("t3.h", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd1);
    step("t3.i", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd1);
    step("t3.j", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2);
    chk_cnt("t3.ch1", 2'd1, 2);

    // ch3 to S101, then clear while requesting with bit 1: no grant, then no detection.
    step("t4.a", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd2);
    step("t4.b", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd2);
    step("t4.c", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd2);
    step("t4.clr", 4'b1001, 4'b1001, 4'b1000, 4'b0001, 1'b0, 2'd2);
    step("t4.d", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd2);
    chk_cnt("t4.ch3", 2'd3, 0);
    chk_cnt("t4.ch2", 2'd2, 2);

    // ch0 to S101, reset mid-stream, then bit 1: no detection and ch0 granted first.
    step("t5.a", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd2);
    step("t5.b", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd2);
    reset_dut("t5");
    step("t5.c", 4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0);

    // 260 overlapped matches on ch2: counter saturates at 255.
    reset_dut("t6");
    step("t6.lead", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
    for (int k = 0; k < 260; k++) begin
      step($sformatf("t6.k%0d.0", k), 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0,
           (k == 0) ? 2'd0 : 2'd2);
      step($sformatf("t6.k%0d.1", k), 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0,
           (k == 0) ? 2'd0 : 2'd2);
      step($sformatf("t6.k%0d.2", k), 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2);
      if (k == 253) chk_cnt("t6.ch2_254", 2'd2, 254);
      if (k == 254) chk_cnt("t6.ch2_255", 2'd2, 255);
    end
    chk_cnt("t6.ch2_sat", 2'd2, 255);
    chk_cnt("t6.ch0", 2'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
